fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 133 +++++++++++++
 tb/tb_fetch_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word fetches to instruction memory and
// buffers returned words in a small in-order queue for the datapath.
// Redirects flush the queue and restart fetching at a new address; a
// request already on the bus is always allowed to finish, its data dropped.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // nothing outstanding on the memory bus
    S_WAIT = 2'd1,  // request outstanding, returned word will be queued
    S_DROP = 2'd2   // request outstanding, returned word is stale
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  count_q, count_d;
  logic [1:0]  count_mid;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        imem_req_q, imem_req_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic [31:0] q_inst_q [DEPTH];
  logic [31:0] q_inst_d [DEPTH];
  logic [31:0] q_pc_q   [DEPTH];
  logic [31:0] q_pc_d   [DEPTH];
  logic        enq, deq, issue;
  logic [31:0] redirect_base;
  logic        unused_redirect_lsb;

  // Redirect targets are always word aligned; the low two bits carry no meaning.
  assign redirect_base       = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Queue update: head always sits in slot 0 so the outputs come straight from flops.
  always_comb begin
    q_inst_d  = q_inst_q;
    q_pc_d    = q_pc_q;
    count_mid = count_q;
    count_d   = count_q;
    deq       = (count_q != 2'd0) && inst_ready && !redirect;
    enq       = (state_q == S_WAIT) && imem_ack && !redirect;
    if (redirect) begin
      count_d = 2'd0;
    end else begin
      if (deq) begin
        q_inst_d[0] = q_inst_q[1];
        q_pc_d[0]   = q_pc_q[1];
        count_mid   = count_q - 2'd1;
      end
      count_d = count_mid;
      if (enq && (count_mid < 2'(DEPTH))) begin
        q_inst_d[count_mid[0]] = imem_rdata;
        q_pc_d[count_mid[0]]   = fetch_pc_q;
        count_d                = count_mid + 2'd1;
      end
    end
  end

  // Fetch control: a new request is launched whenever the bus is (or becomes)
  // free and the queue will still have room once that request returns.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      fetch_pc_d = redirect_base;
    end else if (enq) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    issue = !redirect && (count_d < 2'(DEPTH)) &&
            ((state_q == S_IDLE) || imem_ack);

    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (issue) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (redirect)      state_d = imem_ack ? S_IDLE : S_DROP;
        else if (imem_ack) state_d = issue ? S_WAIT : S_IDLE;
      end
      S_DROP: begin
        if (imem_ack)      state_d = issue ? S_WAIT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    imem_req_d  = (state_d != S_IDLE);
    imem_addr_d = issue ? fetch_pc_d : imem_addr_q;
  end

  // State, queue and bus-output registers; reset abandons any in-flight request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      count_q     <= 2'd0;
      fetch_pc_q  <= RESET_PC;
      imem_req_q  <= 1'b0;
      imem_addr_q <= 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
        q_inst_q[i] <= 32'd0;
        q_pc_q[i]   <= 32'd0;
      end
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      fetch_pc_q  <= fetch_pc_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      q_inst_q    <= q_inst_d;
      q_pc_q      <= q_pc_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = imem_addr_q;
  assign inst_valid = (count_q != 2'd0);
  assign inst_out   = q_inst_q[0];
  assign inst_pc    = q_pc_q[0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, back-pressure, redirects,
// address alignment/wrap and asynchronous reset during a request.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        auto_ack;
  logic        man_ack;

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5EED_C0DE;
  endfunction

  // Memory model: zero-wait when auto_ack, otherwise ack driven by the tests.
  assign imem_ack   = auto_ack ? imem_req : man_ack;
  assign imem_rdata = mem_word(imem_addr);

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc),
    .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ae, input logic rdy);
    rst = 1'b0; man_ack = 1'b0; auto_ack = ae; inst_ready = rdy;
    redirect = 1'b0; redirect_pc = 32'd0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; man_ack = 1'b0; auto_ack = 1'b0; inst_ready = 1'b0;
    redirect = 1'b0; redirect_pc = 32'd0;
    #2;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0h exp=0", imem_req); end
    total++; if (imem_addr !== 32'd0) begin bad++; $display("FAIL reset_addr got=%0h exp=0", imem_addr); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", inst_valid); end
    total++; if (inst_out !== 32'd0) begin bad++; $display("FAIL reset_out got=%0h exp=0", inst_out); end
    total++; if (inst_pc !== 32'd0) begin bad++; $display("FAIL reset_pc got=%0h exp=0", inst_pc); end
    do_reset(1'b0, 1'b0);
    step();
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL first_req got=%0h exp=1", imem_req); end
    total++; if (imem_addr !== 32'd0) begin bad++; $display("FAIL first_addr got=%0h exp=0", imem_addr); end
  endtask

  task automatic test_stream();
    do_reset(1'b1, 1'b1);
    step();
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL stream_e1_valid got=%0h exp=0", inst_valid); end
    for (int k = 2; k < 10; k++) begin
      step();
      total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL stream_valid k=%0d got=%0h exp=1", k, inst_valid); end
      total++; if (inst_pc !== 32'(4 * (k - 2))) begin bad++; $display("FAIL stream_pc k=%0d got=%0h exp=%0h", k, inst_pc, 4 * (k - 2)); end
      total++; if (inst_out !== mem_word(32'(4 * (k - 2)))) begin bad++; $display("FAIL stream_out k=%0d got=%0h exp=%0h", k, inst_out, mem_word(32'(4 * (k - 2)))); end
    end
  endtask

  task automatic test_full();
    do_reset(1'b1, 1'b0);
    step(); step(); step();
    for (int k = 3; k < 7; k++) begin
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL full_req k=%0d got=%0h exp=0", k, imem_req); end
      total++; if (inst_valid !== 1'b1 || inst_pc !== 32'd0) begin bad++; $display("FAIL full_head k=%0d got=%0h/%0h exp=1/0", k, inst_valid, inst_pc); end
      if (k < 6) step();
    end
    inst_ready = 1'b1;
    step();
    total++; if (inst_pc !== 32'd4) begin bad++; $display("FAIL full_second got=%0h exp=4", inst_pc); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'd8) begin bad++; $display("FAIL full_resume got=%0h/%0h exp=1/8", imem_req, imem_addr); end
    step();
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'd8) begin bad++; $display("FAIL full_pc8 got=%0h/%0h exp=1/8", inst_valid, inst_pc); end
  endtask

  task automatic test_redirect_wait();
    do_reset(1'b0, 1'b1);
    step();
    man_ack = 1'b1;
    step(); step();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'd8) begin bad++; $display("FAIL rw_req8 got=%0h/%0h exp=1/8", imem_req, imem_addr); end
    total++; if (inst_pc !== 32'd4) begin bad++; $display("FAIL rw_head4 got=%0h exp=4", inst_pc); end
    man_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'd8) begin bad++; $display("FAIL rw_hold k=%0d got=%0h/%0h exp=1/8", k, imem_req, imem_addr); end
      total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rw_flush k=%0d got=%0h exp=0", k, inst_valid); end
      if (k < 2) step();
    end
    man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin bad++; $display("FAIL rw_next got=%0h/%0h exp=1/40", imem_req, imem_addr); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rw_dropped got=%0h/%0h exp=0", inst_valid, inst_pc); end
    step();
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rw_still_empty got=%0h exp=0", inst_valid); end
    man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h40) begin bad++; $display("FAIL rw_pc40 got=%0h/%0h exp=1/40", inst_valid, inst_pc); end
    total++; if (inst_out !== mem_word(32'h40)) begin bad++; $display("FAIL rw_out40 got=%0h exp=%0h", inst_out, mem_word(32'h40)); end
  endtask

  task automatic test_redirect_ack();
    do_reset(1'b0, 1'b0);
    step();
    man_ack = 1'b1; redirect = 1'b1; redirect_pc = 32'h13;
    step();
    man_ack = 1'b0; redirect = 1'b0;
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL ra_not_queued got=%0h exp=0", inst_valid); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL ra_idle got=%0h exp=0", imem_req); end
    step();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin bad++; $display("FAIL ra_align got=%0h/%0h exp=1/10", imem_req, imem_addr); end
  endtask

  task automatic test_wrap();
    do_reset(1'b0, 1'b0);
    step();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin bad++; $display("FAIL wrap_drop_hold got=%0h/%0h exp=1/0", imem_req, imem_addr); end
    man_ack = 1'b1;
    step();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_top got=%0h/%0h exp=1/fffffffc", imem_req, imem_addr); end
    step();
    man_ack = 1'b0;
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_head got=%0h/%0h exp=1/fffffffc", inst_valid, inst_pc); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin bad++; $display("FAIL wrap_zero got=%0h/%0h exp=1/0", imem_req, imem_addr); end
  endtask

  task automatic test_async_reset();
    #3;
    rst = 1'b0;
    #1;
    total++; if (imem_req !== 1'b0 || imem_addr !== 32'd0) begin bad++; $display("FAIL ar_bus got=%0h/%0h exp=0/0", imem_req, imem_addr); end
    total++; if (inst_valid !== 1'b0 || inst_out !== 32'd0 || inst_pc !== 32'd0) begin bad++; $display("FAIL ar_queue got=%0h/%0h/%0h exp=0/0/0", inst_valid, inst_out, inst_pc); end
    man_ack = 1'b1;
    step();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL ar_held got=%0h exp=0", imem_req); end
    man_ack = 1'b0;
    rst = 1'b1;
    step();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin bad++; $display("FAIL ar_restart got=%0h/%0h exp=1/0", imem_req, imem_addr); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL ar_empty got=%0h exp=0", inst_valid); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_redirect_wait();
    test_redirect_ack();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
